// File: rtl/sitcp_xg_pkg.sv
// Shared definitions for the SiTCP-XG transmit-side data path.
package sitcp_xg_pkg;

    // Byte counts presented on USER_TX_B
    localparam logic [3:0] TX_B_NONE = 4'd0;
    localparam logic [3:0] TX_B_HALF = 4'd4;
    localparam logic [3:0] TX_B_FULL = 4'd8;

    // Packer state: whether a first word is currently held
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } tx_state_e;

    // Reorder a 32-bit word so its least significant byte is placed in the
    // most significant lane, which SiTCP-XG transmits first.
    function automatic logic [31:0] bswap32_le(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sitcp_xg_tx_packer.sv
// Packs pairs of 32-bit FWFT FIFO words into 64-bit SiTCP-XG transmit beats,
// little-endian on the wire, with a timeout flush for a lone trailing word.
module sitcp_xg_tx_packer
    import sitcp_xg_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 256,
    parameter int CNT_WIDTH     = 16
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        ENABLE,
    input  logic        FIFO_EMPTY_IN,
    input  logic [31:0] FIFO_DATA,
    output logic        FIFO_READ_NEXT_OUT,
    input  logic        TX_ESTABLISHED,
    input  logic        TX_AFULL,
    output logic [63:0] TX_D,
    output logic [3:0]  TX_B,
    output logic [63:0] SENT_BYTES
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FLUSH_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    tx_state_e             state_q, state_d;
    logic [31:0]           w0_q, w0_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [63:0]           tx_d_q, tx_d_d;
    logic [3:0]            tx_b_q, tx_b_d;
    logic [63:0]           sent_bytes_q, sent_bytes_d;

    logic                  go;
    logic                  pop;

    // Pop gating is purely combinational so AFULL stops popping in the same cycle
    assign go  = ENABLE & TX_ESTABLISHED & ~TX_AFULL;
    assign pop = go & ~FIFO_EMPTY_IN & ~BUS_RST;

    assign FIFO_READ_NEXT_OUT = pop;
    assign TX_D               = tx_d_q;
    assign TX_B               = tx_b_q;
    assign SENT_BYTES         = sent_bytes_q;

    // Next-state: word pairing, timeout flush, and session/enable discard
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        cnt_d   = cnt_q;
        tx_d_d  = tx_d_q;
        tx_b_d  = TX_B_NONE;

        if (!(ENABLE && TX_ESTABLISHED)) begin
            // Session closed or disabled: drop any held word, never flush it
            state_d = EMPTY;
            w0_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    cnt_d = '0;
                    if (pop) begin
                        w0_d    = FIFO_DATA;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (pop) begin
                        // A pop always wins over a coincident timeout
                        tx_d_d  = {bswap32_le(w0_q), bswap32_le(FIFO_DATA)};
                        tx_b_d  = TX_B_FULL;
                        w0_d    = '0;
                        cnt_d   = '0;
                        state_d = EMPTY;
                    end else if (go) begin
                        if (cnt_q == CNT_LAST) begin
                            tx_d_d  = {bswap32_le(w0_q), 32'h0};
                            tx_b_d  = TX_B_HALF;
                            w0_d    = '0;
                            cnt_d   = '0;
                            state_d = EMPTY;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    // go=0 here means AFULL: counter and held word both hold
                end
                default: begin
                    state_d = EMPTY;
                    w0_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Byte counter tracks exactly what is handed over this edge; wraps at 2^64
    assign sent_bytes_d = sent_bytes_q + {60'd0, tx_b_d};

    // State and output registers with synchronous reset
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q      <= EMPTY;
            w0_q         <= '0;
            cnt_q        <= '0;
            tx_d_q       <= '0;
            tx_b_q       <= TX_B_NONE;
            sent_bytes_q <= '0;
        end else begin
            state_q      <= state_d;
            w0_q         <= w0_d;
            cnt_q        <= cnt_d;
            tx_d_q       <= tx_d_d;
            tx_b_q       <= tx_b_d;
            sent_bytes_q <= sent_bytes_d;
        end
    end

endmodule

// File: tb/tb_sitcp_xg_tx_packer.sv
// Directed bench for the SiTCP-XG transmit packer.
module tb_sitcp_xg_tx_packer;
    import sitcp_xg_pkg::*;

    localparam int T = 16;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic        ENABLE;
    logic        FIFO_EMPTY_IN;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ_NEXT_OUT;
    logic        TX_ESTABLISHED;
    logic        TX_AFULL;
    logic [63:0] TX_D;
    logic [3:0]  TX_B;
    logic [63:0] SENT_BYTES;

    int n_cmp;
    int n_fail;

    logic [31:0] fq[$];

    sitcp_xg_tx_packer #(.FLUSH_TIMEOUT(T), .CNT_WIDTH(16)) dut (
        .BUS_CLK           (BUS_CLK),
        .BUS_RST           (BUS_RST),
        .ENABLE            (ENABLE),
        .FIFO_EMPTY_IN     (FIFO_EMPTY_IN),
        .FIFO_DATA         (FIFO_DATA),
        .FIFO_READ_NEXT_OUT(FIFO_READ_NEXT_OUT),
        .TX_ESTABLISHED    (TX_ESTABLISHED),
        .TX_AFULL          (TX_AFULL),
        .TX_D              (TX_D),
        .TX_B              (TX_B),
        .SENT_BYTES        (SENT_BYTES)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    function automatic void fifo_refresh();
        FIFO_EMPTY_IN = (fq.size() == 0);
        FIFO_DATA     = (fq.size() == 0) ? 32'h0 : fq[0];
    endfunction

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        fifo_refresh();
    endtask

    task automatic fifo_clear();
        fq.delete();
        fifo_refresh();
    endtask

    // FWFT FIFO model: pop on strobe, present new head shortly after the edge
    always @(posedge BUS_CLK) begin
        if (FIFO_READ_NEXT_OUT === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        #1;
        fifo_refresh();
    end

    task automatic tick();
        @(posedge BUS_CLK);
        #2;
    endtask

    function automatic logic [31:0] bs(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic do_reset();
        BUS_RST = 1'b1;
        TX_AFULL = 1'b0;
        fifo_clear();
        tick();
        tick();
        BUS_RST = 1'b0;
        ENABLE = 1'b1;
        TX_ESTABLISHED = 1'b1;
    endtask

    task automatic test_reset();
        BUS_RST = 1'b1;
        ENABLE = 1'b1;
        TX_ESTABLISHED = 1'b1;
        TX_AFULL = 1'b0;
        fifo_clear();
        push(32'h12345678);
        #1;
        n_cmp++;
        if (FIFO_READ_NEXT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: got %b expected 0", FIFO_READ_NEXT_OUT);
        end
        tick();
        tick();
        n_cmp++;
        if (TX_D !== 64'h0 || TX_B !== 4'd0 || SENT_BYTES !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got D=%h B=%0d S=%0d expected 0/0/0", TX_D, TX_B, SENT_BYTES);
        end
        n_cmp++;
        if (dut.state_q !== EMPTY) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected EMPTY", dut.state_q);
        end
        fifo_clear();
        BUS_RST = 1'b0;
    endtask

    task automatic test_pair();
        do_reset();
        push(32'h03020100);
        push(32'h07060504);
        tick();
        n_cmp++;
        if (TX_B !== 4'd0) begin
            n_fail++;
            $display("FAIL pair_first_word: TX_B got %0d expected 0", TX_B);
        end
        tick();
        n_cmp++;
        if (TX_B !== 4'd8 || TX_D !== 64'h0001020304050607 || SENT_BYTES !== 64'd8) begin
            n_fail++;
            $display("FAIL pair_beat: got B=%0d D=%h S=%0d expected 8/0001020304050607/8", TX_B, TX_D, SENT_BYTES);
        end
        tick();
        n_cmp++;
        if (TX_B !== 4'd0 || TX_D !== 64'h0001020304050607 || FIFO_READ_NEXT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_idle: got B=%0d D=%h rd=%b expected 0/hold/0", TX_B, TX_D, FIFO_READ_NEXT_OUT);
        end
    endtask

    task automatic test_timeout();
        int nz;
        // Continues from test_pair: SENT_BYTES starts at 8
        push(32'hAABBCCDD);
        tick();
        nz = 0;
        for (int i = 0; i < T - 1; i++) begin
            tick();
            if (TX_B !== 4'd0) nz++;
        end
        n_cmp++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL timeout_wait: got %0d early beats expected 0", nz);
        end
        tick();
        n_cmp++;
        if (TX_B !== 4'd4 || TX_D !== 64'hDDCCBBAA00000000 || SENT_BYTES !== 64'd12) begin
            n_fail++;
            $display("FAIL timeout_flush: got B=%0d D=%h S=%0d expected 4/DDCCBBAA00000000/12", TX_B, TX_D, SENT_BYTES);
        end
        // Boundary: second word shows up in the very cycle the timeout would fire
        push(32'h11223344);
        tick();
        for (int i = 0; i < T - 1; i++) tick();
        push(32'h55667788);
        tick();
        n_cmp++;
        if (TX_B !== 4'd8 || TX_D !== 64'h4433221188776655 || SENT_BYTES !== 64'd20) begin
            n_fail++;
            $display("FAIL timeout_boundary: got B=%0d D=%h S=%0d expected 8/4433221188776655/20", TX_B, TX_D, SENT_BYTES);
        end
        nz = 0;
        for (int i = 0; i < T + 2; i++) begin
            tick();
            if (TX_B !== 4'd0) nz++;
        end
        n_cmp++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL timeout_boundary_extra: got %0d extra beats expected 0", nz);
        end
    endtask

    task automatic test_afull_stream();
        logic [31:0] exp_q[$];
        logic [31:0] w;
        logic [63:0] exp_d;
        int beats, bad_data, bad_gate, bad_beat, cyc;
        logic afull_prev;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            w = $urandom();
            fq.push_back(w);
            exp_q.push_back(w);
        end
        fifo_refresh();
        beats = 0; bad_data = 0; bad_gate = 0; bad_beat = 0; cyc = 0;
        afull_prev = 1'b0;
        while (beats < 500 && cyc < 5000) begin
            tick();
            cyc++;
            if (afull_prev && TX_B !== 4'd0) bad_beat++;
            if (TX_B === 4'd8) begin
                beats++;
                if (exp_q.size() >= 2) begin
                    exp_d[63:32] = bs(exp_q.pop_front());
                    exp_d[31:0]  = bs(exp_q.pop_front());
                    if (TX_D !== exp_d) bad_data++;
                end else begin
                    bad_data++;
                end
            end else if (TX_B !== 4'd0) begin
                bad_data++;
            end
            TX_AFULL = ($urandom_range(0, 2) == 0);
            afull_prev = TX_AFULL;
            #1;
            if (TX_AFULL && FIFO_READ_NEXT_OUT !== 1'b0) bad_gate++;
        end
        TX_AFULL = 1'b0;
        n_cmp++;
        if (beats !== 500) begin
            n_fail++;
            $display("FAIL stream_beats: got %0d expected 500", beats);
        end
        n_cmp++;
        if (bad_data !== 0) begin
            n_fail++;
            $display("FAIL stream_order: got %0d bad beats expected 0", bad_data);
        end
        n_cmp++;
        if (bad_gate !== 0) begin
            n_fail++;
            $display("FAIL stream_pop_afull: got %0d pops under AFULL expected 0", bad_gate);
        end
        n_cmp++;
        if (bad_beat !== 0) begin
            n_fail++;
            $display("FAIL stream_beat_afull: got %0d late beats expected 0", bad_beat);
        end
        n_cmp++;
        if (SENT_BYTES !== 64'd4000) begin
            n_fail++;
            $display("FAIL stream_sent: got %0d expected 4000", SENT_BYTES);
        end
    endtask

    task automatic test_session_drop();
        int nz;
        do_reset();
        push(32'hAAAA0001);
        tick();
        TX_ESTABLISHED = 1'b0;
        tick();
        nz = 0;
        for (int i = 0; i < T + 4; i++) begin
            tick();
            if (TX_B !== 4'd0) nz++;
        end
        n_cmp++;
        if (nz !== 0 || dut.state_q !== EMPTY) begin
            n_fail++;
            $display("FAIL session_discard: got beats=%0d state=%b expected 0/EMPTY", nz, dut.state_q);
        end
        push(32'h04030201);
        push(32'h08070605);
        TX_ESTABLISHED = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (TX_B !== 4'd8 || TX_D !== 64'h0102030405060708 || SENT_BYTES !== 64'd8) begin
            n_fail++;
            $display("FAIL session_fresh_beat: got B=%0d D=%h S=%0d expected 8/0102030405060708/8", TX_B, TX_D, SENT_BYTES);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        push(32'h33221100);
        push(32'h77665544);
        push(32'hBBAA9988);
        push(32'hFFEEDDCC);
        tick();
        tick();
        n_cmp++;
        if (TX_B !== 4'd8 || SENT_BYTES !== 64'd8) begin
            n_fail++;
            $display("FAIL rst_pre_beat: got B=%0d S=%0d expected 8/8", TX_B, SENT_BYTES);
        end
        BUS_RST = 1'b1;
        #1;
        n_cmp++;
        if (FIFO_READ_NEXT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_read: got %b expected 0", FIFO_READ_NEXT_OUT);
        end
        tick();
        n_cmp++;
        if (TX_B !== 4'd0 || SENT_BYTES !== 64'd0 || TX_D !== 64'h0 || dut.state_q !== EMPTY) begin
            n_fail++;
            $display("FAIL rst_clear: got B=%0d S=%0d D=%h st=%b expected 0/0/0/EMPTY", TX_B, SENT_BYTES, TX_D, dut.state_q);
        end
        BUS_RST = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (TX_B !== 4'd8 || TX_D !== 64'h8899AABBCCDDEEFF || SENT_BYTES !== 64'd8) begin
            n_fail++;
            $display("FAIL rst_resume: got B=%0d D=%h S=%0d expected 8/8899AABBCCDDEEFF/8", TX_B, TX_D, SENT_BYTES);
        end
    endtask

    task automatic test_sent_wrap();
        do_reset();
        force dut.sent_bytes_q = 64'hFFFF_FFFF_FFFF_FFF8;
        #1;
        release dut.sent_bytes_q;
        push(32'hDEADBEEF);
        push(32'hCAFEF00D);
        tick();
        n_cmp++;
        if (SENT_BYTES !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_preset: got %h expected FFFFFFFFFFFFFFF8", SENT_BYTES);
        end
        tick();
        n_cmp++;
        if (TX_B !== 4'd8 || SENT_BYTES !== 64'h0 || TX_D !== 64'hEFBEADDE0DF0FECA) begin
            n_fail++;
            $display("FAIL wrap_zero: got B=%0d S=%h D=%h expected 8/0/EFBEADDE0DF0FECA", TX_B, SENT_BYTES, TX_D);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        BUS_RST = 1'b1;
        ENABLE = 1'b0;
        TX_ESTABLISHED = 1'b0;
        TX_AFULL = 1'b0;
        fifo_refresh();
        test_reset();
        test_pair();
        test_timeout();
        test_afull_stream();
        test_session_drop();
        test_midstream_reset();
        test_sent_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
